transpose_chunk_sched: RTL and testbench
========================================

// Module: transpose_chunk_sched
// PURPOSE
//  Job-level scheduler for the chunked matrix-transpose datapath. On start it walks every
//  CHUNK_SIZE x CHUNK_SIZE chunk of an ARR_SIZE x ARR_SIZE array, row-major, and issues each
//  chunk to the transpose unit (in_val/ctrl/base_addr/chunk_addr) as source data arrives.
//  Store-buffer credits throttle issue because the transpose pipeline cannot stall. Completion
//  is tracked by counting out_val returns, and done is raised once all chunks have drained.
// PARAMETERS
//  ADDR_WIDTH   64  width of byte addresses
//  DATA_WIDTH   64  element width in bits; ELEM_BYTES = DATA_WIDTH/8
//  ARR_SIZE     8   array width/height in elements
//  CHUNK_SIZE   8   chunk width/height in elements; ARR_SIZE % CHUNK_SIZE == 0
//  CREDITS      4   store-buffer slots; max chunks issued but not yet freed by the store side
//  MAX_OUTST    16  outstanding-counter capacity (chunks issued, no out_val yet); >= pipeline depth
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           async active-low reset
//  start         in   1           1-cycle pulse, begin job; ignored unless state==IDLE
//  abort         in   1           1-cycle pulse, stop issuing and drain; ignored in IDLE
//  cfg_ctrl      in   1           transpose mode, sampled on start and held for the job
//  cfg_base_addr in   ADDR_WIDTH  array base byte address, sampled on start
//  src_valid     in   1           chunk data present at transpose input
//  src_ready     out  1           chunk consumed this cycle (== issue)
//  tp_in_val     out  1           registered issue strobe to transpose unit
//  tp_ctrl       out  1           registered copy of latched cfg_ctrl
//  tp_base_addr  out  ADDR_WIDTH  registered latched base address
//  tp_chunk_addr out  ADDR_WIDTH  registered byte address of the issued chunk
//  tp_out_val    in   1           transpose unit produced one chunk
//  st_free       in   1           store side released one buffer slot (returns one credit)
//  busy          out  1           state != IDLE
//  done          out  1           1-cycle pulse at job end
//  aborted       out  1           1 if the last job ended by abort; cleared on start
//  err           out  1           sticky: out_val with zero outstanding, or credit overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all counters 0; every output 0, except credit=CREDITS.
//  Derived: NCH = ARR_SIZE/CHUNK_SIZE; total chunks = NCH*NCH.
//  FSM IDLE->RUN on start: latch cfg; crow=ccol=0; credit=CREDITS; aborted=0.
//   RUN->DRAIN after the last chunk (crow=ccol=NCH-1) issues, or on abort.
//   DRAIN->DONE when outstanding==0. DONE->IDLE the next cycle, with done=1 in DONE only.
//  Issue (comb) = state==RUN && src_valid && credit!=0 && outstanding!=MAX_OUTST.
//   src_ready = issue. tp_in_val is issue registered (1 cycle later), with tp_chunk_addr =
//   cfg_base_addr + (crow*CHUNK_SIZE*ARR_SIZE + ccol*CHUNK_SIZE)*ELEM_BYTES, mod 2^ADDR_WIDTH.
//   tp_chunk_addr holds its last value when tp_in_val=0.
//  Chunk walk: on issue ccol++; at ccol==NCH-1 it wraps to 0 and crow++. No wrap past the last
//   chunk, because the FSM leaves RUN.
//  Credit uses start-of-cycle value; no same-cycle bypass of st_free. Issue && st_free -> no
//   change. st_free at credit==CREDITS -> ignored, err=1. st_free accepted in every state.
//  Outstanding: +1 on issue, -1 on tp_out_val, net 0 if both in one cycle. tp_out_val at 0 ->
//   count stays 0, err=1.
//  Abort in RUN with a same-cycle issue: the issue completes, then DRAIN; aborted=1 at DONE.
//   Abort in DRAIN/DONE has no effect. Start while busy is ignored and does not set err.
//  rst_n low mid-job: immediate return to IDLE; in-flight out_val after release sets err only
//   if outstanding==0 (expected).
//  tp_ctrl/tp_base_addr are constant from the cycle after start until the next start.
// TESTING
//  T1 ARR=16,CHUNK=8,base=0x1000,src_valid=1,st_free echoes out_val 2 cycles later -> 4 issues,
//     chunk_addr 0x1000,0x1040,0x1400,0x1440; done 1 cycle after outstanding hits 0.
//  T2 CREDITS=2, st_free held 0 -> exactly 2 issues then src_ready=0; one st_free -> 1 more.
//  T3 src_valid toggled 1,0,1,0 -> issues only on valid cycles; chunk order unchanged; no gaps.
//  T4 abort after 2nd issue of 4 -> no further src_ready; done after 2 out_val; aborted=1.
//  T5 tp_out_val while idle -> err=1 sticky; start pulsed while busy -> no effect.
//  T6 rst_n low mid-RUN -> busy=0, tp_in_val=0, credit restored; new start runs a clean job.

Source files
------------

// File: rtl/transpose_chunk_sched.sv
// Job-level scheduler for the chunked matrix transpose: walks chunks row-major,
// issues them under store-buffer credit and outstanding limits, and reports completion.
module transpose_chunk_sched #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ARR_SIZE   = 8,
  parameter int unsigned CHUNK_SIZE = 8,
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned MAX_OUTST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_ctrl,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic                  tp_in_val,
  output logic                  tp_ctrl,
  output logic [ADDR_WIDTH-1:0] tp_base_addr,
  output logic [ADDR_WIDTH-1:0] tp_chunk_addr,
  input  logic                  tp_out_val,
  input  logic                  st_free,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err
);

  localparam int unsigned ELEM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned NCH        = ARR_SIZE / CHUNK_SIZE;
  localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CRW        = $clog2(CREDITS + 1);
  localparam int unsigned OW         = $clog2(MAX_OUTST + 1);
  localparam int unsigned ROW_STRIDE = CHUNK_SIZE * ARR_SIZE * ELEM_BYTES;
  localparam int unsigned COL_STRIDE = CHUNK_SIZE * ELEM_BYTES;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         crow, ccol;
  logic [CRW-1:0]        credit;
  logic [OW-1:0]         outst;
  logic                  abort_pend;
  logic                  issue, last_col, last_chunk, credit_full;
  logic [ADDR_WIDTH-1:0] chunk_addr;

  // Issue qualification and address of the chunk at the walk position
  always_comb begin
    issue       = (state == RUN) && src_valid && (credit != '0) && (outst != OW'(MAX_OUTST));
    last_col    = (ccol == CW'(NCH - 1));
    last_chunk  = last_col && (crow == CW'(NCH - 1));
    credit_full = (credit == CRW'(CREDITS));
    chunk_addr  = tp_base_addr
                + ADDR_WIDTH'(crow) * ADDR_WIDTH'(ROW_STRIDE)
                + ADDR_WIDTH'(ccol) * ADDR_WIDTH'(COL_STRIDE);
  end

  assign src_ready = issue;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (abort || (issue && last_chunk)) state_nxt = DRAIN;
      DRAIN:   if (outst == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      crow          <= '0;
      ccol          <= '0;
      credit        <= CRW'(CREDITS);
      outst         <= '0;
      abort_pend    <= 1'b0;
      tp_in_val     <= 1'b0;
      tp_ctrl       <= 1'b0;
      tp_base_addr  <= '0;
      tp_chunk_addr <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err           <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      tp_in_val <= issue;

      // Job setup on start, otherwise advance the row-major walk per issue
      if (state == IDLE && start) begin
        tp_ctrl      <= cfg_ctrl;
        tp_base_addr <= cfg_base_addr;
        crow         <= '0;
        ccol         <= '0;
        aborted      <= 1'b0;
        abort_pend   <= 1'b0;
      end else if (issue) begin
        tp_chunk_addr <= chunk_addr;
        if (!last_chunk) begin
          if (last_col) begin
            ccol <= '0;
            crow <= crow + CW'(1);
          end else begin
            ccol <= ccol + CW'(1);
          end
        end
      end

      if (state == RUN && abort) abort_pend <= 1'b1;
      if (state == DRAIN && state_nxt == DONE) aborted <= abort_pend;

      // Credits use the start-of-cycle count; a free while full is an error
      if (state == IDLE && start) begin
        credit <= CRW'(CREDITS);
      end else if (issue && !st_free) begin
        credit <= credit - CRW'(1);
      end else if (!issue && st_free) begin
        if (credit_full) err <= 1'b1;
        else             credit <= credit + CRW'(1);
      end

      if (issue && !tp_out_val) begin
        outst <= outst + OW'(1);
      end else if (!issue && tp_out_val) begin
        if (outst == '0) err <= 1'b1;
        else             outst <= outst - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_transpose_chunk_sched.sv
// Directed bench for transpose_chunk_sched: 16x16 array of 8x8 chunks, two credits.
module tb_transpose_chunk_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, cfg_ctrl, src_valid;
  logic [63:0] cfg_base_addr;
  logic        src_ready, tp_in_val, tp_ctrl;
  logic [63:0] tp_base_addr, tp_chunk_addr;
  logic        tp_out_val, st_free;
  logic        busy, done, aborted, err;

  logic        model_en, man_out_val, man_st_free;
  logic [2:0]  out_pipe;
  logic [1:0]  free_pipe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  transpose_chunk_sched #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ARR_SIZE(16), .CHUNK_SIZE(8),
    .CREDITS(2), .MAX_OUTST(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_ctrl(cfg_ctrl), .cfg_base_addr(cfg_base_addr),
    .src_valid(src_valid), .src_ready(src_ready),
    .tp_in_val(tp_in_val), .tp_ctrl(tp_ctrl),
    .tp_base_addr(tp_base_addr), .tp_chunk_addr(tp_chunk_addr),
    .tp_out_val(tp_out_val), .st_free(st_free),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  // Transpose unit returns a chunk 3 cycles after issue; store frees it 2 cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pipe  <= '0;
      free_pipe <= '0;
    end else begin
      out_pipe  <= {out_pipe[1:0], model_en & tp_in_val};
      free_pipe <= {free_pipe[0], model_en & tp_out_val};
    end
  end

  assign tp_out_val = model_en ? out_pipe[2]  : man_out_val;
  assign st_free    = model_en ? free_pipe[1] : man_st_free;

  typedef struct {
    logic [4:0]  in;    // {start, abort, src_valid, out_val, st_free}
    logic [1:0]  exp_c; // {src_ready before edge, tp_in_val after edge}
    logic [63:0] addr;
    logic [1:0]  exp_s; // {busy, done} after edge
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [4:0] i, input logic [1:0] c,
                              input logic [63:0] a, input logic [1:0] s);
    vec_t v;
    v.in = i; v.exp_c = c; v.addr = a; v.exp_s = s;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk1({nm, "_done_seen"}, done, 1'b1);
  endtask

  // Full job with the pipeline model; optionally pulses start mid-job with bogus config
  task automatic model_job(input logic [63:0] base, input logic ctrl,
                           input bit poke_start, input string nm);
    logic [63:0] got[$];
    logic [63:0] offs[4];
    logic [63:0] a;
    int k;
    bit seen;
    offs[0] = 64'h0; offs[1] = 64'h40; offs[2] = 64'h400; offs[3] = 64'h440;
    cfg_base_addr = base; cfg_ctrl = ctrl; model_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; src_valid = 1'b1;
    chk1({nm, "_aborted_clr"}, aborted, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b1);
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      if (poke_start && k == 2) begin
        start = 1'b1; cfg_base_addr = 64'hdead_0000; cfg_ctrl = ~ctrl;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      if (tp_in_val) got.push_back(tp_chunk_addr);
      if (done) seen = 1'b1;
    end
    start = 1'b0; src_valid = 1'b0;
    chk1({nm, "_done_seen"}, seen, 1'b1);
    chk_int({nm, "_issues"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = '1;
      if (i < got.size()) a = got[i];
      chk64($sformatf("%s_addr%0d", nm, i), a, base + offs[i]);
    end
    chk64({nm, "_base"}, tp_base_addr, base);
    chk1({nm, "_ctrl"}, tp_ctrl, ctrl);
    tick();
    chk1({nm, "_done_pulse"}, done, 1'b0);
    chk1({nm, "_idle"}, busy, 1'b0);
    repeat (6) tick();
    model_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_ctrl = 1'b0; cfg_base_addr = '0;
    src_valid = 1'b0; model_en = 1'b0; man_out_val = 1'b0; man_st_free = 1'b0;

    // Reset state
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_in_val", tp_in_val, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_aborted", aborted, 1'b0);
    chk1("rst_ready", src_ready, 1'b0);
    chk64("rst_chunk_addr", tp_chunk_addr, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Manual job: gapped valid, credit starvation, no-bypass free, drain
    tbl[0]  = mk(5'b10000, 2'b00, 64'h0,    2'b10);
    tbl[1]  = mk(5'b00100, 2'b11, 64'h1000, 2'b10);
    tbl[2]  = mk(5'b00000, 2'b00, 64'h1000, 2'b10);
    tbl[3]  = mk(5'b00100, 2'b11, 64'h1040, 2'b10);
    tbl[4]  = mk(5'b00100, 2'b00, 64'h1040, 2'b10);
    tbl[5]  = mk(5'b00101, 2'b00, 64'h1040, 2'b10);
    tbl[6]  = mk(5'b00100, 2'b11, 64'h1400, 2'b10);
    tbl[7]  = mk(5'b00111, 2'b00, 64'h1400, 2'b10);
    tbl[8]  = mk(5'b00101, 2'b11, 64'h1440, 2'b10);
    tbl[9]  = mk(5'b00110, 2'b00, 64'h1440, 2'b10);
    tbl[10] = mk(5'b00010, 2'b00, 64'h1440, 2'b10);
    tbl[11] = mk(5'b00010, 2'b00, 64'h1440, 2'b10);
    tbl[12] = mk(5'b00000, 2'b00, 64'h1440, 2'b11);
    tbl[13] = mk(5'b00000, 2'b00, 64'h1440, 2'b00);
    cfg_base_addr = 64'h1000; cfg_ctrl = 1'b0;
    for (int i = 0; i < 14; i++) begin
      {start, abort, src_valid, man_out_val, man_st_free} = tbl[i].in;
      #1;
      chk1($sformatf("tbl%0d_ready", i), src_ready, tbl[i].exp_c[1]);
      tick();
      chk1($sformatf("tbl%0d_in_val", i), tp_in_val, tbl[i].exp_c[0]);
      chk64($sformatf("tbl%0d_addr", i), tp_chunk_addr, tbl[i].addr);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_s[1]);
      chk1($sformatf("tbl%0d_done", i), done, tbl[i].exp_s[0]);
      chk1($sformatf("tbl%0d_err", i), err, 1'b0);
    end
    {start, abort, src_valid, man_out_val, man_st_free} = 5'b0;
    chk64("tbl_base", tp_base_addr, 64'h1000);

    // Free-running job through the pipeline model
    model_job(64'h1000, 1'b1, 1'b0, "t1");
    chk1("t1_err", err, 1'b0);

    // Credit throttling with no frees, then one free, then abort to end
    cfg_base_addr = 64'h1000; start = 1'b1;
    tick();
    start = 1'b0; src_valid = 1'b1; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1; cnt += int'(src_ready); tick();
    end
    chk_int("t2_issues_no_free", cnt, 2);
    man_st_free = 1'b1;
    #1; cnt += int'(src_ready); tick();
    man_st_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; cnt += int'(src_ready); tick();
    end
    chk_int("t2_issues_one_free", cnt, 3);
    src_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("t2_drain_busy", busy, 1'b1);
    man_out_val = 1'b1;
    repeat (3) tick();
    man_out_val = 1'b0;
    wait_done("t2");
    chk1("t2_aborted", aborted, 1'b1);
    chk1("t2_err", err, 1'b0);
    tick();

    // Abort coinciding with the second issue
    cfg_base_addr = 64'h2000; start = 1'b1;
    tick();
    start = 1'b0; src_valid = 1'b1;
    tick();
    abort = 1'b1;
    #1;
    chk1("t4_ready_with_abort", src_ready, 1'b1);
    tick();
    abort = 1'b0;
    chk1("t4_in_val", tp_in_val, 1'b1);
    chk64("t4_addr", tp_chunk_addr, 64'h2040);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1; cnt += int'(src_ready); tick();
    end
    chk_int("t4_no_issue_after_abort", cnt, 0);
    src_valid = 1'b0; man_out_val = 1'b1;
    repeat (2) tick();
    man_out_val = 1'b0;
    wait_done("t4");
    chk1("t4_aborted", aborted, 1'b1);
    chk1("t4_err", err, 1'b0);
    tick();

    // Spurious out_val while idle, then start pulsed while busy
    man_out_val = 1'b1;
    tick();
    man_out_val = 1'b0;
    chk1("t5_err_set", err, 1'b1);
    model_job(64'h3000, 1'b1, 1'b1, "t5");
    chk1("t5_err_sticky", err, 1'b1);

    // Reset mid-job, then a clean job
    cfg_base_addr = 64'h5000; model_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; src_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_in_val", tp_in_val, 1'b0);
    chk1("t6_err_clr", err, 1'b0);
    chk1("t6_done", done, 1'b0);
    src_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_job(64'h6000, 1'b0, 1'b0, "t6");
    chk1("t6_err_clean", err, 1'b0);

    // Free returned while all credits are home
    man_st_free = 1'b1;
    tick();
    man_st_free = 1'b0;
    chk1("t6_credit_overflow_err", err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
